// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter ticked by a clock-enable prescaler,
// pulsing done for one cycle when the count reaches zero.
module countdown_timer #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] countValue,
    output logic             running,
    output logic             done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_next;
    logic [PW-1:0]    r_pre, w_pre_next;
    logic [WIDTH-1:0] r_count, w_count_next;
    logic             r_done, w_done_next;
    logic             w_adv, w_tick, w_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pre   <= w_pre_next;
            r_count <= w_count_next;
            r_done  <= w_done_next;
        end
    end

    // load outranks a tick, so a load on the expiry edge swallows the old done
    always_comb begin
        w_adv        = (r_state == RUN) && enable;
        w_tick       = w_adv && (r_pre == PRE_MAX);
        w_last       = w_tick && (r_count == WIDTH'(1));
        w_state_next = load ? ((loadValue != '0) ? RUN : IDLE) : (w_last ? IDLE : r_state);
        w_pre_next   = (load || w_tick) ? '0 : (w_adv ? r_pre + 1'b1 : r_pre);
        w_count_next = load ? loadValue : (w_tick ? r_count - 1'b1 : r_count);
        w_done_next  = load ? (loadValue == '0) : w_last;
    end

    always_comb begin
        countValue = r_count;
        running    = (r_state == RUN);
        done       = r_done;
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table vectors, directed corner sequences and random
// stimulus checked against an elapsed-cycle reference model.
module tb_countdown_timer;
    localparam int TD = 4;

    logic       clock = 0;
    logic       reset = 0;
    logic       enable = 0;
    logic       load = 0;
    logic [3:0] loadValue = '0;
    logic [3:0] countValue;
    logic       running, done;

    int errors = 0;
    int checks = 0;

    countdown_timer #(.WIDTH(4), .TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .loadValue(loadValue), .countValue(countValue), .running(running), .done(done)
    );

    always #5 clock = ~clock;

    // Model: value loaded plus enabled RUN cycles elapsed since the load.
    int m_v = 0, m_e = 0;
    bit m_run = 0, m_done = 0;

    function automatic void model_clear();
        m_v = 0; m_e = 0; m_run = 0; m_done = 0;
    endfunction

    function automatic void model_edge(bit rn, bit en, bit ld, int lv);
        if (!rn) model_clear();
        else if (ld) begin
            m_v = lv; m_e = 0; m_run = (lv != 0); m_done = (lv == 0);
        end else begin
            m_done = 0;
            if (m_run && en) begin
                m_e++;
                if (m_e == m_v * TD) begin m_run = 0; m_done = 1; end
            end
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".count"}, countValue, (m_v - m_e / TD) & 15);
        chk({tag, ".running"}, running, m_run);
        chk({tag, ".done"}, done, m_done);
    endtask

    task automatic tick(input string tag);
        model_edge(reset, enable, load, loadValue);
        @(posedge clock); #1;
        chk_model(tag);
    endtask

    task automatic drive(input bit en, input bit ld, input int lv);
        enable = en; load = ld; loadValue = 4'(lv);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 0;
        #1 model_clear();
        chk({tag, ".count"}, countValue, 0);
        chk({tag, ".running"}, running, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    typedef struct {
        bit       ld;
        bit       en;
        bit [3:0] lv;
        bit [3:0] cnt;
        bit       run;
        bit       dn;
    } vec_t;

    vec_t tbl[14];
    int   ndone;

    initial begin
        tbl = '{
            '{1, 1, 3, 3, 1, 0}, '{0, 1, 0, 3, 1, 0}, '{0, 1, 0, 3, 1, 0}, '{0, 1, 0, 3, 1, 0},
            '{0, 1, 0, 2, 1, 0}, '{0, 1, 0, 2, 1, 0}, '{0, 1, 0, 2, 1, 0}, '{0, 1, 0, 2, 1, 0},
            '{0, 1, 0, 1, 1, 0}, '{0, 1, 0, 1, 1, 0}, '{0, 1, 0, 1, 1, 0}, '{0, 1, 0, 1, 1, 0},
            '{0, 1, 0, 0, 0, 1}, '{0, 1, 0, 0, 0, 0}
        };
        #1 chk_model("reset_initial");
        tick("reset_hold");
        tick("reset_hold");
        reset = 1;
        tick("idle");

        // basic countdown of 3
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].en, tbl[i].ld, tbl[i].lv);
            model_edge(reset, enable, load, loadValue);
            @(posedge clock); #1;
            chk($sformatf("table[%0d].count", i), countValue, tbl[i].cnt);
            chk($sformatf("table[%0d].running", i), running, tbl[i].run);
            chk($sformatf("table[%0d].done", i), done, tbl[i].dn);
        end

        // pause: 10 disabled cycles after edge 5 push expiry from edge 20 to 30
        drive(1, 1, 5);
        tick("pause.load");
        for (int e = 1; e <= 31; e++) begin
            drive((e >= 6 && e <= 15) ? 0 : 1, 0, 0);
            tick("pause");
            if (e >= 5 && e <= 15) chk("pause.hold_count", countValue, 4);
            if (e == 20) chk("pause.no_done_20", done, 0);
            if (e == 30) chk("pause.done_30", done, 1);
        end

        // reload mid-run
        ndone = 0;
        drive(1, 1, 9);
        tick("reload.load9");
        for (int e = 1; e <= 16; e++) begin
            drive(1, e == 6, 2);
            tick("reload");
            ndone += done;
            if (e == 6) chk("reload.count_after_6", countValue, 2);
            if (e == 14) chk("reload.done_14", done, 1);
        end
        chk("reload.single_done", ndone, 1);

        // load colliding with expiry
        drive(1, 1, 1);
        tick("collide.load1");
        for (int e = 1; e <= 4; e++) begin
            drive(1, e == 4, 3);
            tick("collide");
        end
        chk("collide.no_done", done, 0);
        chk("collide.count", countValue, 3);
        chk("collide.running", running, 1);

        // load zero
        drive(1, 1, 0);
        tick("load0");
        chk("load0.done", done, 1);
        chk("load0.running", running, 0);
        drive(1, 0, 0);
        tick("load0.after");
        chk("load0.done_clear", done, 0);

        // reset mid-run
        drive(1, 1, 15);
        tick("rstmid.load");
        drive(1, 0, 0);
        for (int e = 1; e <= 6; e++) tick("rstmid.run");
        async_reset("rstmid.async");
        tick("rstmid.low");
        tick("rstmid.low");
        reset = 1;
        ndone = 0;
        for (int e = 0; e < 72; e++) begin
            tick("rstmid.after");
            ndone += done;
        end
        chk("rstmid.no_done", ndone, 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom % 16);
            if (($urandom % 250) == 0) begin
                async_reset("rand.async");
                tick("rand.rstlow");
                reset = 1;
            end else tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a clock-enable prescaler. It is the counterpart to the free-running up counter: it takes a preset value, counts it down to zero at a programmable tick rate, then raises a single-cycle `done` pulse. In the Pong design it times the serve delay and the round countdown shown on the display, driven from the 50 MHz system clock.

## Interface

Parameters:
- `WIDTH`, default 4: width of the count value and of the load value.
- `TICK_DIV`, default 50000000: system clocks per count tick. Legal values are ≥ 2. The prescaler width is `$clog2(TICK_DIV)`.

Ports:
- `clock`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. Low clears all state immediately, without waiting for a clock edge.
- `enable`  input  1  high lets the prescaler advance. Low pauses the countdown and holds all state.
- `load`  input  1  synchronous load strobe.
- `loadValue`  input  `WIDTH`  preset value, sampled when `load` is high.
- `countValue`  output  `WIDTH`  current remaining count (registered).
- `running`  output  1  high while in RUN state (registered).
- `done`  output  1  one-cycle pulse on expiry (registered).

## Operation

- **States.** The block has two states, IDLE and RUN. `running` equals (state == RUN). An internal prescaler `pre` has range 0 to `TICK_DIV`-1.
- **Reset.** While `reset` is 0: state = IDLE, `pre` = 0, `countValue` = 0, `done` = 0, `running` = 0.
- **Priority at each edge:** `load`, then tick, then hold.
- **Load** (any state, `enable` ignored):
  - `countValue` ← `loadValue`, `pre` ← 0.
  - If `loadValue` ≠ 0, state ← RUN and `done` ← 0.
  - If `loadValue` = 0, state ← IDLE and `done` ← 1. This is the immediate-expiry case.
- **RUN with `enable` = 1 and `pre` < `TICK_DIV`-1:** `pre` increments.
- **Tick** is RUN with `enable` = 1 and `pre` = `TICK_DIV`-1. On a tick:
  - `pre` ← 0.
  - `countValue` decrements by 1, with no wrap.
  - If the pre-tick `countValue` was 1: state ← IDLE and `done` ← 1.
- **RUN with `enable` = 0:** `pre`, `countValue` and state all hold. The countdown resumes from the same prescaler phase when `enable` returns high.
- **IDLE without load:** all state holds. `countValue` stays at 0 after expiry, or at the last loaded value.
- **`done` width.** `done` is high for exactly one cycle, then returns to 0 on the next edge unless another expiry occurs on that edge.
- **Arithmetic.** Unsigned, modulo-free. `countValue` never decrements below 0, because RUN is never entered with a count of 0.

## Timing

- **Latency.** Load at edge L with value V ≠ 0 and `enable` held high:
  - decrement k occurs at edge L + k·`TICK_DIV`;
  - `countValue` reaches 0 and `done` is high in the cycle after edge L + V·`TICK_DIV`.
- **Pausing.** Each cycle with `enable` low in RUN extends expiry by one cycle.
- **Load colliding with a tick or expiry.** Load wins. No decrement occurs and no `done` pulse is produced for the old count. The new count restarts with full prescaler phase.
- **Load of 0.** `done` is high in the cycle immediately after the load edge. `running` stays 0.
- **Maximum value.** `loadValue` = 2^`WIDTH`-1 is legal; at the default `WIDTH`, 15 expires after 15·`TICK_DIV` cycles.
- **Reset mid-operation.**
  - Outputs clear asynchronously on the falling edge of `reset`.
  - On release, the block sits in IDLE with `countValue` 0 and emits no `done`.
  - Release is assumed synchronised upstream.
- **Output registration.** All outputs come directly from registers, with no combinational path from inputs.

## Test plan

All scenarios use `TICK_DIV` = 4 and `WIDTH` = 4, with the load edge counted as edge 0.

- **Reset:** drive `reset` = 0 mid-cycle → `countValue` = 0, `running` = 0 and `done` = 0 before the next clock edge.
- **Basic countdown:** load 3 with `enable` = 1 → `countValue` reads 3, 2, 1, 0 after edges 0, 4, 8, 12. `done` is high only in the cycle after edge 12, and `running` falls at the same edge.
- **Pause:** load 5 with `enable` = 1, then drop `enable` for 10 cycles starting after edge 5 → `countValue` holds at 4 during the pause, and `done` fires after edge 30 rather than edge 20.
- **Reload mid-run:** load 9, then load 2 at edge 6 → `countValue` = 2 after edge 6, `done` after edge 14, and no pulse for the original count. A load asserted on the same edge as the old expiry also suppresses the old `done`.
- **Load zero:** load 0 → `done` high for exactly one cycle after the load edge, `running` stays 0, `countValue` = 0.
- **Reset mid-run:** load 15, then pull `reset` low at cycle 7 for 2 cycles → outputs clear immediately. After release, `countValue` = 0, `running` = 0, and `done` stays 0 for at least 70 cycles.
